// File: rtl/scroll_msg_ctrl_if.sv
// Handshake and display bus between the user/control logic and scroll_msg_ctrl.
// master = control side (drives load/run/dir/clear), slave = the controller.
interface scroll_msg_if;
  logic        clear;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] msg_data;
  logic        run;
  logic        dir;
  logic [3:0]  hex3;
  logic [3:0]  hex2;
  logic [3:0]  hex1;
  logic [3:0]  hex0;
  logic [3:0]  dp_out;
  logic        busy;
  logic        wrap_pulse;
  logic [2:0]  pos;

  modport master (
    output clear, load_valid, msg_data, run, dir,
    input  load_ready, hex3, hex2, hex1, hex0, dp_out, busy, wrap_pulse, pos
  );

  modport slave (
    input  clear, load_valid, msg_data, run, dir,
    output load_ready, hex3, hex2, hex1, hex0, dp_out, busy, wrap_pulse, pos
  );
endinterface

// File: rtl/scroll_msg_ctrl.sv
// Scrolling 8-digit hex message sequencer feeding a 4-digit seven-segment scanner.
// Shows a circular 4-digit window of the stored message, stepping it at a
// programmable rate; new messages arrive over a valid/ready handshake.

// One display position: picks message digit m[(p+OFF)%8] and flags the
// start-of-message digit with its decimal point.
module scroll_digit_sel #(
  parameter int OFF = 0
) (
  input  logic [31:0] msg_i,
  input  logic [2:0]  p_i,
  input  logic        active_i,
  output logic [3:0]  digit_o,
  output logic        dp_o
);
  logic [2:0] idx;

  // Index wraps naturally in 3 bits
  always_comb begin
    idx     = p_i + 3'(OFF);
    digit_o = msg_i[{idx, 2'b00} +: 4];
    dp_o    = active_i & (idx == 3'd0);
  end
endmodule

module scroll_msg_ctrl #(
  parameter int STEP_CYCLES = 25000000,
  parameter int CNT_W       = 25
) (
  input  logic        clk,
  input  logic        reset,
  scroll_msg_if.slave bus
);
  localparam int NUM_DIGITS = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SCROLL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      msg_q, msg_d;
  logic [2:0]       p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic             load_ready;
  logic             step;

  logic [NUM_DIGITS-1:0][3:0] hex_w;
  logic [NUM_DIGITS-1:0]      dp_w;

  assign load_ready = (state_q != ST_SCROLL);
  assign step       = (state_q == ST_SCROLL) && (cnt_q == CNT_LAST);

  // State register: reset > everything, otherwise take the computed next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      msg_q   <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next state: clear > load > run; step and run-drop may coincide
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    if (bus.clear) begin
      state_d = ST_IDLE;
      msg_d   = '0;
      p_d     = '0;
      cnt_d   = '0;
    end else if (bus.load_valid && load_ready) begin
      state_d = ST_HOLD;
      msg_d   = bus.msg_data;
      p_d     = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (bus.run) begin
            state_d = ST_SCROLL;
            cnt_d   = '0;
          end
        end
        ST_SCROLL: begin
          if (step) begin
            cnt_d = '0;
            if (bus.dir) begin
              p_d    = p_q - 3'd1;
              wrap_d = (p_q == 3'd0);
            end else begin
              p_d    = p_q + 3'd1;
              wrap_d = (p_q == 3'd7);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          if (!bus.run) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Display position k shows m[(p + 3 - k) % 8]; k=3 is the leftmost digit
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    scroll_digit_sel #(.OFF(NUM_DIGITS - 1 - k)) u_sel (
      .msg_i    (msg_q),
      .p_i      (p_q),
      .active_i (state_q != ST_IDLE),
      .digit_o  (hex_w[k]),
      .dp_o     (dp_w[k])
    );
  end

  assign bus.hex3       = hex_w[3];
  assign bus.hex2       = hex_w[2];
  assign bus.hex1       = hex_w[1];
  assign bus.hex0       = hex_w[0];
  assign bus.dp_out     = dp_w;
  assign bus.load_ready = load_ready;
  assign bus.busy       = (state_q == ST_SCROLL);
  assign bus.wrap_pulse = wrap_q;
  assign bus.pos        = p_q;
endmodule

// File: tb/tb_scroll_msg_ctrl.sv
// Directed bench for scroll_msg_ctrl with STEP_CYCLES=4.
module tb_scroll_msg_ctrl;
  logic clk;
  logic reset;
  int   n_run;
  int   n_fail;

  scroll_msg_if bus ();

  scroll_msg_ctrl #(.STEP_CYCLES(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one edge, then settle before sampling/driving
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] hexw();
    return {bus.hex3, bus.hex2, bus.hex1, bus.hex0};
  endfunction

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.clear = 1'b0;
    bus.load_valid = 1'b0;
    bus.msg_data = '0;
    bus.run = 1'b0;
    bus.dir = 1'b0;
    tick(2);
    reset = 1'b0;

    chk("rst_ready", bus.load_ready, 1);
    chk("rst_hex",   hexw(), 16'h0000);
    chk("rst_dp",    bus.dp_out, 4'b0000);
    chk("rst_busy",  bus.busy, 0);
    chk("rst_pos",   bus.pos, 0);
    chk("rst_wrap",  bus.wrap_pulse, 0);

    // run is ignored in IDLE
    bus.run = 1'b1;
    tick();
    chk("idle_run_busy", bus.busy, 0);
    bus.run = 1'b0;

    // Load in IDLE
    bus.msg_data = 32'h76543210;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    chk("ld_hex",   hexw(), 16'h0123);
    chk("ld_dp",    bus.dp_out, 4'b1000);
    chk("ld_ready", bus.load_ready, 1);
    chk("ld_busy",  bus.busy, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("hold_pos", bus.pos, 0);
    end

    // Scroll forward
    bus.run = 1'b1;
    bus.dir = 1'b0;
    tick();
    chk("scr_busy", bus.busy, 1);
    chk("scr_pos0", bus.pos, 0);
    tick(3);
    chk("scr_pos_e3", bus.pos, 0);
    tick();
    chk("scr_pos1", bus.pos, 1);
    chk("scr_hex1", hexw(), 16'h1234);
    tick(16);
    chk("scr_pos5", bus.pos, 5);
    chk("scr_hex5", hexw(), 16'h5670);
    chk("scr_dp5",  bus.dp_out, 4'b0001);
    tick(8);
    chk("scr_pos7", bus.pos, 7);
    tick(3);
    chk("pre_wrap", bus.wrap_pulse, 0);
    tick();
    chk("wrap_pos",  bus.pos, 0);
    chk("wrap_hex",  hexw(), 16'h0123);
    chk("wrap_fwd",  bus.wrap_pulse, 1);
    tick();
    chk("wrap_end",  bus.wrap_pulse, 0);

    // Reverse from pos 0 (cnt is 1 now, step edge 3 ticks away)
    bus.dir = 1'b1;
    tick(3);
    chk("rev_pos",  bus.pos, 7);
    chk("rev_hex",  hexw(), 16'h7012);
    chk("rev_dp",   bus.dp_out, 4'b0100);
    chk("rev_wrap", bus.wrap_pulse, 1);
    tick();
    chk("rev_wrap_end", bus.wrap_pulse, 0);

    // Load attempt while scrolling is refused
    bus.msg_data = 32'hFEDCBA98;
    bus.load_valid = 1'b1;
    chk("scr_ready", bus.load_ready, 0);
    tick();
    bus.load_valid = 1'b0;
    chk("scr_noload", hexw(), 16'h7012);
    chk("scr_busy2",  bus.busy, 1);
    bus.run = 1'b0;
    tick();
    chk("pause_busy",  bus.busy, 0);
    chk("pause_pos",   bus.pos, 7);
    chk("pause_ready", bus.load_ready, 1);

    // Load with run=1 in the same cycle: load wins
    bus.load_valid = 1'b1;
    bus.run = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    chk("ldrun_busy", bus.busy, 0);
    chk("ldrun_pos",  bus.pos, 0);
    chk("ldrun_hex",  hexw(), 16'h89AB);
    chk("ldrun_dp",   bus.dp_out, 4'b1000);
    tick();
    chk("ldrun_scr",  bus.busy, 1);

    // Clear with load on a step edge
    bus.dir = 1'b0;
    tick(3);
    bus.clear = 1'b1;
    bus.load_valid = 1'b1;
    bus.msg_data = 32'h12345678;
    tick();
    bus.clear = 1'b0;
    bus.load_valid = 1'b0;
    chk("clr_busy", bus.busy, 0);
    chk("clr_pos",  bus.pos, 0);
    chk("clr_hex",  hexw(), 16'h0000);
    chk("clr_dp",   bus.dp_out, 4'b0000);
    chk("clr_wrap", bus.wrap_pulse, 0);
    tick();
    chk("clr_idle", bus.busy, 0);
    chk("clr_wrap2", bus.wrap_pulse, 0);

    // Reset mid-scroll
    bus.run = 1'b0;
    bus.msg_data = 32'hAAAA5555;
    bus.load_valid = 1'b1;
    tick();
    bus.load_valid = 1'b0;
    chk("ld3_hex", hexw(), 16'h5555);
    bus.run = 1'b1;
    tick(6);
    chk("ld3_pos", bus.pos, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.run = 1'b0;
    chk("mrst_busy",  bus.busy, 0);
    chk("mrst_pos",   bus.pos, 0);
    chk("mrst_hex",   hexw(), 16'h0000);
    chk("mrst_dp",    bus.dp_out, 4'b0000);
    chk("mrst_ready", bus.load_ready, 1);
    chk("mrst_wrap",  bus.wrap_pulse, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
